// File: rtl/buzzer_pkg.sv
// Shared constants and helpers for the buzzer PCM generator: tone increments,
// amplitude levels, one-shot burst lengths and the amplitude ramp step function.
package buzzer_pkg;

    localparam int CNT_W = 13;
    localparam logic [CNT_W-1:0] ONE_SHOT_SHORT = 13'd1500;
    localparam logic [CNT_W-1:0] ONE_SHOT_LONG  = 13'd6000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } oneshot_state_t;

    // Phase increment per 48 kHz sample: round(f * 2^24 / 48000), f = 32768 / {8,10,12,14,16,20,24,28}.
    function automatic logic [23:0] freq_inc(input logic [2:0] sel);
        logic [23:0] inc;
        case (sel)
            3'd0:    inc = 24'd1431656;
            3'd1:    inc = 24'd1145325;
            3'd2:    inc = 24'd954437;
            3'd3:    inc = 24'd818089;
            3'd4:    inc = 24'd715828;
            3'd5:    inc = 24'd572662;
            3'd6:    inc = 24'd477219;
            3'd7:    inc = 24'd409045;
            default: inc = 24'd0;
        endcase
        return inc;
    endfunction

    function automatic logic [14:0] level_amp(input logic [2:0] sel);
        logic [14:0] lvl;
        case (sel)
            3'd0:    lvl = 15'h0000;
            3'd1:    lvl = 15'h0800;
            3'd2:    lvl = 15'h1000;
            3'd3:    lvl = 15'h1800;
            3'd4:    lvl = 15'h2000;
            3'd5:    lvl = 15'h2800;
            3'd6:    lvl = 15'h3000;
            3'd7:    lvl = 15'h4000;
            default: lvl = 15'h0000;
        endcase
        return lvl;
    endfunction

    // Move cur one step toward tgt, landing exactly on tgt instead of overshooting.
    function automatic logic [14:0] ramp_toward(input logic [14:0] cur,
                                                input logic [14:0] tgt,
                                                input logic [14:0] step);
        logic [14:0] nxt;
        if (cur < tgt) begin
            if ((tgt - cur) > step) nxt = cur + step;
            else                    nxt = tgt;
        end else if (cur > tgt) begin
            if ((cur - tgt) > step) nxt = cur - step;
            else                    nxt = tgt;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/buzzer_pcm_gen_tick.sv
// Fractional-rate tick generator: drift-free OUT_RATE pulses derived from a
// CLK_RATE clock with a wrap-and-subtract accumulator.
module frac_tick_gen #(
    parameter int unsigned CLK_RATE = 24576000,
    parameter int unsigned OUT_RATE = 48000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [31:0] CLK_W = 32'(CLK_RATE);
    localparam logic [31:0] OUT_W = 32'(OUT_RATE);

    logic [31:0] acc_r;
    logic [31:0] acc_sum_s;

    assign acc_sum_s = acc_r + OUT_W;

    // Accumulate the output rate; on crossing CLK_RATE wrap the remainder and pulse tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= 32'd0;
            tick  <= 1'b0;
        end else if (acc_sum_s >= CLK_W) begin
            acc_r <= acc_sum_s - CLK_W;
            tick  <= 1'b1;
        end else begin
            acc_r <= acc_sum_s;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/buzzer_pcm_gen.sv
// Buzzer-to-PCM converter: square tone with linear attack/release ramp,
// selectable level and a retriggerable one-shot burst, emitted as signed stereo samples.
module buzzer_pcm_gen
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 24576000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter logic [15:0] RAMP_STEP   = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        buzzer_en,
    input  logic [2:0]  freq_sel,
    input  logic [2:0]  level_sel,
    input  logic        one_shot_trig,
    input  logic        one_shot_long,
    output logic [15:0] pcm_l,
    output logic [15:0] pcm_r,
    output logic        sample_valid,
    output logic        one_shot_busy
);

    logic             tick_s;
    oneshot_state_t   state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             long_r;
    logic [14:0]      amp_r, amp_next_s, target_s;
    logic [23:0]      phase_r, phase_next_s;
    logic             active_s;
    logic             polarity_s;
    logic [15:0]      sample_s;

    frac_tick_gen #(
        .CLK_RATE (CLK_RATE),
        .OUT_RATE (SAMPLE_RATE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // One-shot next state: a trigger always (re)loads, so it wins over same-cycle expiry.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (one_shot_trig) begin
                    state_s = RUN;
                    cnt_s   = long_r ? ONE_SHOT_LONG : ONE_SHOT_SHORT;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (one_shot_trig) begin
                    cnt_s = long_r ? ONE_SHOT_LONG : ONE_SHOT_SHORT;
                end else if (tick_s) begin
                    if (cnt_r <= 13'd1) begin
                        cnt_s   = 13'd0;
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r - 13'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 13'd0;
            end
        endcase
    end

    assign active_s   = buzzer_en | one_shot_busy;
    assign polarity_s = ~phase_r[23];

    // Per-sample datapath; phase parks at zero while silent so each tone opens on the positive half.
    always_comb begin
        target_s = 15'd0;
        if (active_s) target_s = level_amp(level_sel);
        else          target_s = 15'd0;
        amp_next_s = ramp_toward(amp_r, target_s, RAMP_STEP[14:0]);
        if ((amp_r == 15'd0) && !active_s) phase_next_s = 24'd0;
        else                               phase_next_s = phase_r + freq_inc(freq_sel);
        if (polarity_s) sample_s = {1'b0, amp_next_s};
        else            sample_s = 16'd0 - {1'b0, amp_next_s};
    end

    // State, ramp, phase and output registers; the sample datapath advances only on tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= 13'd0;
            one_shot_busy <= 1'b0;
            long_r        <= 1'b0;
            amp_r         <= 15'd0;
            phase_r       <= 24'd0;
            pcm_l         <= 16'd0;
            pcm_r         <= 16'd0;
            sample_valid  <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            one_shot_busy <= (state_s == RUN);
            sample_valid  <= tick_s;
            if (tick_s) begin
                long_r  <= one_shot_long;
                amp_r   <= amp_next_s;
                phase_r <= phase_next_s;
                pcm_l   <= sample_s;
                pcm_r   <= sample_s;
            end else begin
                long_r  <= long_r;
                amp_r   <= amp_r;
                phase_r <= phase_r;
                pcm_l   <= pcm_l;
                pcm_r   <= pcm_r;
            end
        end
    end

endmodule

// File: tb/tb_buzzer_pcm_gen.sv
// Directed + randomized bench for buzzer_pcm_gen against an arithmetic reference
// model of tick timing, ramp, tone phase and one-shot burst length.
module tb_buzzer_pcm_gen;

    localparam int unsigned T_CLK_RATE = 192000;   // 4 clks per sample keeps long bursts affordable
    localparam int PER = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        buzzer_en = 1'b0;
    logic [2:0]  freq_sel = 3'd0;
    logic [2:0]  level_sel = 3'd0;
    logic        one_shot_trig = 1'b0;
    logic        one_shot_long = 1'b0;
    logic [15:0] pcm_l, pcm_r, d_pcm_l, d_pcm_r;
    logic        sample_valid, one_shot_busy, d_valid, d_busy;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc;
    int          ticks;
    logic        last_ticked;
    int          m_amp;
    logic [23:0] m_phase;
    logic [15:0] m_pcm;
    logic        m_busy;
    int          m_rem;
    logic        m_long;
    longint      inc_tbl [8];
    int          lvl_tbl [8] = '{0, 'h800, 'h1000, 'h1800, 'h2000, 'h2800, 'h3000, 'h4000};
    int          div_tbl [8] = '{8, 10, 12, 14, 16, 20, 24, 28};

    buzzer_pcm_gen #(
        .CLK_RATE    (T_CLK_RATE),
        .SAMPLE_RATE (48000),
        .RAMP_STEP   (16'h0100)
    ) u_dut (
        .clk (clk), .reset (reset), .buzzer_en (buzzer_en), .freq_sel (freq_sel),
        .level_sel (level_sel), .one_shot_trig (one_shot_trig), .one_shot_long (one_shot_long),
        .pcm_l (pcm_l), .pcm_r (pcm_r), .sample_valid (sample_valid), .one_shot_busy (one_shot_busy)
    );

    buzzer_pcm_gen u_dut_def (
        .clk (clk), .reset (reset), .buzzer_en (buzzer_en), .freq_sel (freq_sel),
        .level_sel (level_sel), .one_shot_trig (one_shot_trig), .one_shot_long (one_shot_long),
        .pcm_l (d_pcm_l), .pcm_r (d_pcm_r), .sample_valid (d_valid), .one_shot_busy (d_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mag16(input logic [15:0] v);
        return v[15] ? (65536 - int'(v)) : int'(v);
    endfunction

    task automatic model_reset();
        cyc = 0; m_amp = 0; m_phase = 24'd0; m_pcm = 16'd0;
        m_busy = 1'b0; m_rem = 0; m_long = 1'b0; last_ticked = 1'b0;
    endtask

    // One clock: advance the reference model with the inputs this edge sampled, then compare.
    task automatic step();
        logic active;
        int   tgt, new_amp;
        @(posedge clk); #1;
        cyc++;
        last_ticked = (cyc >= PER + 1) && (((cyc - PER - 1) % PER) == 0);
        active = buzzer_en | m_busy;
        if (last_ticked) begin
            ticks++;
            tgt = active ? lvl_tbl[level_sel] : 0;
            if (m_amp < tgt)      new_amp = (m_amp + 256 > tgt) ? tgt : m_amp + 256;
            else if (m_amp > tgt) new_amp = (m_amp - 256 < tgt) ? tgt : m_amp - 256;
            else                  new_amp = m_amp;
            if (!m_phase[23]) m_pcm = 16'(new_amp);
            else              m_pcm = 16'(0 - new_amp);
            if (m_amp == 0 && !active) m_phase = 24'd0;
            else                       m_phase = m_phase + 24'(inc_tbl[freq_sel]);
            m_amp = new_amp;
        end
        if (one_shot_trig) begin
            m_busy = 1'b1;
            m_rem  = m_long ? 6000 : 1500;
        end else if (m_busy && last_ticked) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        if (last_ticked) m_long = one_shot_long;
        check("valid", 32'(sample_valid), 32'(last_ticked));
        check("busy", 32'(one_shot_busy), 32'(m_busy));
        check("pcm_l", 32'(pcm_l), 32'(m_pcm));
        check("pcm_r", 32'(pcm_r), 32'(m_pcm));
        check("def_valid", 32'(d_valid), 32'((cyc >= 513) && (((cyc - 513) % 512) == 0)));
    endtask

    task automatic wait_ticks(input int k);
        int start;
        start = ticks;
        while (ticks - start < k) step();
    endtask

    task automatic fire_trig();
        one_shot_trig = 1'b1;
        step();
        one_shot_trig = 1'b0;
    endtask

    task automatic ticks_until_idle(input int bound, output int k);
        k = 0;
        while (one_shot_busy && k <= bound) begin
            step();
            if (last_ticked) k++;
        end
    endtask

    initial begin
        int     k, changes, exp_changes;
        logic   last_sign, have_sign;
        longint p_first;

        for (int i = 0; i < 8; i++)
            inc_tbl[i] = ((64'd1 << 40) / longint'(div_tbl[i] * 48000) + 1) / 2;
        model_reset();
        ticks = 0;

        #7;
        check("rst_pcm_l", 32'(pcm_l), 32'd0);
        check("rst_pcm_r", 32'(pcm_r), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_busy", 32'(one_shot_busy), 32'd0);
        check("rst_def_pcm", 32'({d_pcm_l, d_pcm_r}), 32'd0);
        check("rst_def_busy", 32'(d_busy), 32'd0);
        buzzer_en = 1'b1; level_sel = 3'd7; freq_sel = 3'd4;
        #10 reset = 1'b0;

        // Attack then release, 0x100 per sample.
        for (int i = 1; i <= 64; i++) begin
            wait_ticks(1);
            check("ramp_up", 32'(mag16(pcm_l)), 32'(i * 256));
        end
        buzzer_en = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            wait_ticks(1);
            check("ramp_down", 32'(mag16(pcm_l)), 32'(16384 - i * 256));
        end
        wait_ticks(4);
        check("silent", 32'(pcm_l), 32'd0);

        // Steady 4096 Hz tone: only +/-0x4000 and the predicted number of sign flips.
        buzzer_en = 1'b1; freq_sel = 3'd0; level_sel = 3'd7;
        wait_ticks(70);
        p_first = longint'(m_phase);
        changes = 0; have_sign = 1'b0; last_sign = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            wait_ticks(1);
            check("tone_level", 32'(mag16(pcm_l)), 32'd16384);
            if (have_sign && (pcm_l[15] != last_sign)) changes++;
            last_sign = pcm_l[15];
            have_sign = 1'b1;
        end
        exp_changes = int'(((p_first + 1999 * inc_tbl[0]) >> 23) - (p_first >> 23));
        check("tone_sign_changes", 32'(changes), 32'(exp_changes));

        // Single short burst.
        buzzer_en = 1'b0; level_sel = 3'd5; one_shot_long = 1'b0;
        wait_ticks(70);
        fire_trig();
        ticks_until_idle(2000, k);
        check("oneshot_len", 32'(k), 32'd1500);

        // Retrigger after 1000 samples.
        wait_ticks(10);
        fire_trig();
        wait_ticks(1000);
        fire_trig();
        ticks_until_idle(2000, k);
        check("retrig_len", 32'(k), 32'd1500);

        // Trigger landing in the expiry clock reloads with the long length.
        wait_ticks(10);
        fire_trig();
        one_shot_long = 1'b1;
        wait_ticks(1499);
        k = 0;
        while (((cyc + 1 - PER - 1) % PER) != 0 && k < 10) begin
            step();
            k++;
        end
        fire_trig();
        check("collision_busy", 32'(one_shot_busy), 32'd1);
        ticks_until_idle(7000, k);
        check("collision_len", 32'(k), 32'd6000);

        // Randomized segments checked against the model every clock.
        for (int s = 0; s < 30; s++) begin
            buzzer_en     = 1'($urandom_range(0, 1));
            freq_sel      = 3'($urandom_range(0, 7));
            level_sel     = 3'($urandom_range(0, 7));
            one_shot_long = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) fire_trig();
            for (int c = int'($urandom_range(20, 400)); c > 0; c--) step();
        end
        one_shot_long = 1'b0;

        // Asynchronous reset mid-tone at a time not aligned to the clock.
        buzzer_en = 1'b1; level_sel = 3'd7; freq_sel = 3'($urandom_range(0, 7));
        wait_ticks(100);
        #3 reset = 1'b1;
        #1;
        check("arst_pcm", 32'(pcm_l), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        check("arst_busy", 32'(one_shot_busy), 32'd0);
        model_reset();
        #12 reset = 1'b0;
        wait_ticks(1);
        check("post_reset_first", 32'(pcm_l), 32'h0100);
        check("post_reset_cycle", 32'(cyc), 32'(PER + 1));
        wait_ticks(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
